// File: rtl/id_rf_fwd_if.sv
// Bundle between ID decode and the register file / forwarding block.
// Debug write-trace signals exist only when RF_DBG_EN is defined.
interface id_rf_fwd_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD-1:0]      rd_used;
  logic [NRD*XLEN-1:0] rd_data;
  logic                ex_we;
  logic [AW-1:0]       ex_wr;
  logic [XLEN-1:0]     ex_wd;
  logic                mem_we;
  logic [AW-1:0]       mem_wr;
  logic [XLEN-1:0]     mem_wd;
  logic                wb_we;
  logic [AW-1:0]       wb_wr;
  logic [XLEN-1:0]     wb_wd;
  logic                wb_long;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_long;
  logic                stall;
  logic [NREG-1:0]     busy;
  logic [CW-1:0]       pend_cnt;
`ifdef RF_DBG_EN
  logic                dbg_we;
  logic [AW-1:0]       dbg_wr;
  logic [XLEN-1:0]     dbg_wd;
  logic [31:0]         dbg_wcnt;

  modport master (
    output rd_addr, rd_used,
    output ex_we, ex_wr, ex_wd,
    output mem_we, mem_wr, mem_wd,
    output wb_we, wb_wr, wb_wd, wb_long,
    output iss_valid, iss_rd, iss_long,
    input  rd_data, stall, busy, pend_cnt,
    input  dbg_we, dbg_wr, dbg_wd, dbg_wcnt
  );
  modport slave (
    input  rd_addr, rd_used,
    input  ex_we, ex_wr, ex_wd,
    input  mem_we, mem_wr, mem_wd,
    input  wb_we, wb_wr, wb_wd, wb_long,
    input  iss_valid, iss_rd, iss_long,
    output rd_data, stall, busy, pend_cnt,
    output dbg_we, dbg_wr, dbg_wd, dbg_wcnt
  );
`else
  modport master (
    output rd_addr, rd_used,
    output ex_we, ex_wr, ex_wd,
    output mem_we, mem_wr, mem_wd,
    output wb_we, wb_wr, wb_wd, wb_long,
    output iss_valid, iss_rd, iss_long,
    input  rd_data, stall, busy, pend_cnt
  );
  modport slave (
    input  rd_addr, rd_used,
    input  ex_we, ex_wr, ex_wd,
    input  mem_we, mem_wr, mem_wd,
    input  wb_we, wb_wr, wb_wd, wb_long,
    input  iss_valid, iss_rd, iss_long,
    output rd_data, stall, busy, pend_cnt
  );
`endif
endinterface

// File: rtl/id_rf_fwd.sv
// ID-stage register file with EX/MEM/WB forwarding and busy scoreboard.
// Optional write-trace outputs enabled by defining RF_DBG_EN.
module id_rf_fwd #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic        clk,
  input logic        rst_n,
  id_rf_fwd_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREG-1:0] clr, set;
  logic [NRD*XLEN-1:0] rdata;
  logic            wr_ok, iss_ok, raw, waw, stall;

  assign wr_ok = bus.wb_we && !(ZR && bus.wb_wr == '0);

  always_comb begin
    clr = '0;
    for (int r = 0; r < NREG; r++)
      clr[r] = bus.wb_we && bus.wb_long && bus.wb_wr == AW'(r);
  end

  always_comb begin
    logic [AW-1:0] a;
    rdata = '0;
    raw   = 1'b0;
    a     = '0;
    for (int i = 0; i < NRD; i++) begin
      a = bus.rd_addr[i*AW +: AW];
      if (ZR && a == '0)
        rdata[i*XLEN +: XLEN] = '0;
      else if (bus.ex_we && bus.ex_wr == a)
        rdata[i*XLEN +: XLEN] = bus.ex_wd;
      else if (bus.mem_we && bus.mem_wr == a)
        rdata[i*XLEN +: XLEN] = bus.mem_wd;
      else if (bus.wb_we && bus.wb_wr == a)
        rdata[i*XLEN +: XLEN] = bus.wb_wd;
      else
        rdata[i*XLEN +: XLEN] = rf_q[a];
      if (bus.rd_used[i] && busy_q[a] && !clr[a] && !(ZR && a == '0))
        raw = 1'b1;
    end
  end

  // A retire in the same cycle frees the slot, so the new producer may issue.
  assign waw = bus.iss_valid && bus.iss_long &&
               busy_q[bus.iss_rd] && !clr[bus.iss_rd];
  assign stall  = raw || waw;
  assign iss_ok = bus.iss_valid && !stall && bus.iss_long;

  always_comb begin
    set = '0;
    for (int r = 0; r < NREG; r++)
      set[r] = iss_ok && bus.iss_rd == AW'(r) && !(ZR && r == 0);
    busy_d = (busy_q & ~clr) | set;
    cnt_d  = '0;
    for (int r = 0; r < NREG; r++)
      cnt_d = cnt_d + CW'(busy_d[r]);
  end

  always_comb begin
    for (int r = 0; r < NREG; r++)
      rf_d[r] = rf_q[r];
    if (wr_ok)
      rf_d[bus.wb_wr] = bus.wb_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        rf_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        rf_q[r] <= rf_d[r];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.rd_data  = rdata;
  assign bus.stall    = stall;
  assign bus.busy     = busy_q;
  assign bus.pend_cnt = cnt_q;

`ifdef RF_DBG_EN
  logic            dbg_we_q, dbg_we_d;
  logic [AW-1:0]   dbg_wr_q, dbg_wr_d;
  logic [XLEN-1:0] dbg_wd_q, dbg_wd_d;
  logic [31:0]     dbg_wcnt_q, dbg_wcnt_d;

  always_comb begin
    dbg_we_d   = wr_ok;
    dbg_wr_d   = dbg_wr_q;
    dbg_wd_d   = dbg_wd_q;
    dbg_wcnt_d = dbg_wcnt_q;
    if (wr_ok) begin
      dbg_wr_d   = bus.wb_wr;
      dbg_wd_d   = bus.wb_wd;
      dbg_wcnt_d = dbg_wcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_we_q   <= 1'b0;
      dbg_wr_q   <= '0;
      dbg_wd_q   <= '0;
      dbg_wcnt_q <= '0;
    end else begin
      dbg_we_q   <= dbg_we_d;
      dbg_wr_q   <= dbg_wr_d;
      dbg_wd_q   <= dbg_wd_d;
      dbg_wcnt_q <= dbg_wcnt_d;
    end
  end

  assign bus.dbg_we   = dbg_we_q;
  assign bus.dbg_wr   = dbg_wr_q;
  assign bus.dbg_wd   = dbg_wd_q;
  assign bus.dbg_wcnt = dbg_wcnt_q;
`endif
endmodule

// File: tb/tb_id_rf_fwd.sv
// Scoreboard bench for id_rf_fwd: expectations queued with stimulus,
// drained against DUT outputs 1ns after each driving negedge.
module tb_id_rf_fwd;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  localparam int K_RD    = 0;
  localparam int K_STALL = 1;
  localparam int K_BUSY  = 2;
  localparam int K_CNT   = 3;
  localparam int K_BUSYV = 4;

  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [63:0] exp;
  } sb_t;

  sb_t sbq[$];

  id_rf_fwd_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  id_rf_fwd #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] obs(input int kind, input int idx);
    logic [63:0] v;
    v = '0;
    case (kind)
      K_RD:    v = 64'(bus.rd_data[idx*XLEN +: XLEN]);
      K_STALL: v = 64'(bus.stall);
      K_BUSY:  v = 64'(bus.busy[idx]);
      K_CNT:   v = 64'(bus.pend_cnt);
      K_BUSYV: v = 64'(bus.busy);
      default: v = '1;
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int kind, input int idx,
                      input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.kind = kind;
    e.idx = idx;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic idle();
    bus.rd_addr   = '0;
    bus.rd_used   = '0;
    bus.ex_we     = 1'b0;
    bus.ex_wr     = '0;
    bus.ex_wd     = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wr    = '0;
    bus.mem_wd    = '0;
    bus.wb_we     = 1'b0;
    bus.wb_wr     = '0;
    bus.wb_wd     = '0;
    bus.wb_long   = 1'b0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
    bus.iss_long  = 1'b0;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic wb(input int r, input logic [31:0] d, input logic lng);
    bus.wb_we   = 1'b1;
    bus.wb_wr   = AW'(r);
    bus.wb_wd   = d;
    bus.wb_long = lng;
  endtask

  task automatic issue(input int r);
    bus.iss_valid = 1'b1;
    bus.iss_rd    = AW'(r);
    bus.iss_long  = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    idle();
    @(negedge clk);
    set_rd(0, 5);
    set_rd(1, 0);
    push("rst_rd0", K_RD, 0, 0);
    push("rst_rd1", K_RD, 1, 0);
    push("rst_busy", K_BUSYV, 0, 0);
    push("rst_cnt", K_CNT, 0, 0);
    push("rst_stall", K_STALL, 0, 0);
    drain();
    cyc();
    rst_n = 1'b1;
    cyc();

    wb(5, 32'hDEADBEEF, 1'b0);
    set_rd(0, 5);
    push("wt_x5", K_RD, 0, 64'hDEADBEEF);
    drain();
    cyc();
    idle();
    set_rd(0, 5);
    set_rd(1, 0);
    wb(0, 32'h1, 1'b0);
    push("arr_x5", K_RD, 0, 64'hDEADBEEF);
    push("wt_x0", K_RD, 1, 0);
    drain();
    cyc();
    idle();
    set_rd(1, 0);
    bus.ex_we = 1'b1;
    bus.ex_wr = '0;
    bus.ex_wd = 32'h99;
    push("arr_x0", K_RD, 1, 0);
    drain();
    cyc();

    idle();
    set_rd(0, 7);
    bus.ex_we  = 1'b1;
    bus.ex_wr  = 5'd7;
    bus.ex_wd  = 32'h11;
    bus.mem_we = 1'b1;
    bus.mem_wr = 5'd7;
    bus.mem_wd = 32'h22;
    wb(7, 32'h33, 1'b0);
    push("fwd_ex", K_RD, 0, 64'h11);
    drain();
    cyc();
    bus.ex_we = 1'b0;
    push("fwd_mem", K_RD, 0, 64'h22);
    drain();
    cyc();
    bus.mem_we = 1'b0;
    push("fwd_wb", K_RD, 0, 64'h33);
    drain();
    cyc();
    idle();
    set_rd(0, 7);
    push("arr_x7", K_RD, 0, 64'h33);
    drain();
    cyc();

    idle();
    issue(9);
    push("iss9_stall", K_STALL, 0, 0);
    drain();
    cyc();
    idle();
    set_rd(0, 9);
    bus.rd_used = 2'b01;
    push("raw_stall", K_STALL, 0, 1);
    push("raw_cnt", K_CNT, 0, 1);
    push("raw_busy9", K_BUSY, 9, 1);
    drain();
    bus.rd_used = 2'b00;
    push("unused_stall", K_STALL, 0, 0);
    drain();
    bus.rd_used = 2'b01;
    issue(11);
    push("raw_iss_stall", K_STALL, 0, 1);
    drain();
    cyc();
    idle();
    push("ign_busy11", K_BUSY, 11, 0);
    push("ign_cnt", K_CNT, 0, 1);
    drain();
    set_rd(0, 9);
    bus.rd_used = 2'b01;
    wb(9, 32'h55, 1'b1);
    push("ret_stall", K_STALL, 0, 0);
    push("ret_rd", K_RD, 0, 64'h55);
    drain();
    cyc();
    idle();
    push("ret_busy9", K_BUSY, 9, 0);
    push("ret_cnt", K_CNT, 0, 0);
    drain();

    issue(9);
    drain();
    cyc();
    issue(9);
    push("waw_stall", K_STALL, 0, 1);
    drain();
    cyc();
    idle();
    push("waw_busy", K_BUSYV, 0, 64'h200);
    push("waw_cnt", K_CNT, 0, 1);
    drain();
    issue(9);
    wb(9, 32'h66, 1'b1);
    push("reiss_stall", K_STALL, 0, 0);
    drain();
    cyc();
    idle();
    push("reiss_busy9", K_BUSY, 9, 1);
    push("reiss_cnt", K_CNT, 0, 1);
    drain();
    wb(9, 32'h77, 1'b1);
    cyc();
    idle();
    wb(12, 32'h1, 1'b1);
    cyc();
    idle();
    issue(0);
    cyc();
    idle();
    set_rd(0, 0);
    bus.rd_used = 2'b01;
    push("clr_cnt", K_CNT, 0, 0);
    push("clr_busy", K_BUSYV, 0, 0);
    push("x0_stall", K_STALL, 0, 0);
    drain();

    idle();
    issue(3);
    cyc();
    issue(4);
    cyc();
    issue(5);
    cyc();
    idle();
    set_rd(0, 3);
    set_rd(1, 5);
    bus.rd_used = 2'b01;
    push("three_cnt", K_CNT, 0, 3);
    push("three_stall", K_STALL, 0, 1);
    push("pre_rst_x5", K_RD, 1, 64'hDEADBEEF);
    drain();
    #1;
    rst_n = 1'b0;
    push("arst_busy", K_BUSYV, 0, 0);
    push("arst_cnt", K_CNT, 0, 0);
    push("arst_stall", K_STALL, 0, 0);
    push("arst_rd0", K_RD, 0, 0);
    push("arst_rd1", K_RD, 1, 0);
    drain();
    set_rd(0, 7);
    push("arst_x7", K_RD, 0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/id_rf_fwd.md
Name: id_rf_fwd

Overview:
Parametrised successor to the ID-stage register file and write-back path. It provides NRD combinational read ports with EX/MEM/WB forwarding, and WB write-through. A busy-bit scoreboard tracks pending long-latency writes (loads, multi-cycle ops) and raises a stall for the issuing stage. It sits in ID, between the instruction decoder and the EX pipeline register.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (power of 2); AW = $clog2(NREG)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, writes to it dropped

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_used  in  NRD  port i operand is actually consumed (gates stall)
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
ex_we  in  1  EX-stage instruction writes a register with its result ready in EX
ex_wr  in  AW  EX destination
ex_wd  in  XLEN  EX result (alu_c)
mem_we  in  1  MEM-stage write valid with data ready
mem_wr  in  AW  MEM destination
mem_wd  in  XLEN  MEM result
wb_we  in  1  write-back enable (rf_we)
wb_wr  in  AW  write-back destination (wR)
wb_wd  in  XLEN  write-back data (selected wD)
wb_long  in  1  this write-back retires a long-latency op
iss_valid  in  1  ID issues an instruction this cycle
iss_rd  in  AW  destination of issuing instruction
iss_long  in  1  issuing instruction is long-latency
stall  out  1  ID must hold; issue is ignored while high
busy  out  NREG  scoreboard bits
pend_cnt  out  $clog2(NREG+1)  number of set busy bits

Behaviour:
- Reset (rst_n low, async): all registers 0, busy 0, pend_cnt 0. Hence rd_data = 0 and stall = 0 during reset.
- Write: at posedge clk, if wb_we and not (ZERO_REG and wb_wr==0), reg[wb_wr] <= wb_wd.
- Read port i, combinational, first match wins:
  (1) ZERO_REG and addr==0 -> 0
  (2) ex_we and ex_wr==addr -> ex_wd
  (3) mem_we and mem_wr==addr -> mem_wd
  (4) wb_we and wb_wr==addr -> wb_wd (write-through)
  (5) reg[addr]
- Forwarding on register 0 is suppressed when ZERO_REG=1.
- Scoreboard, per register r, at posedge:
  - set when iss_valid and !stall and iss_long and iss_rd==r (r!=0 if ZERO_REG);
  - clear when wb_we and wb_long and wb_wr==r;
  - set and clear on the same r in the same cycle -> set wins (new producer).
- pend_cnt is registered and updated in the same edge as busy; it equals popcount(busy) at all times.
- Stall (combinational) is 1 if either:
  - (RAW) any port i has rd_used[i], busy[addr_i], and NOT (wb_we and wb_long and wb_wr==addr_i); the same-cycle retire is covered by write-through;
  - (WAW) iss_valid and iss_long and busy[iss_rd] and not cleared this cycle.
- Register 0 never stalls when ZERO_REG=1.
- iss_valid with stall=1 has no effect on state. The upstream stage holds the instruction.
- Latency: read 0 cycles; write visible through the array the cycle after the WB edge, and via write-through in the same cycle.
- A clear for a register that is not busy is harmless: no change and no count underflow.
- Reset mid-operation clears all pending entries. In-flight long ops after reset must be flushed upstream.

Optional Feature:
RF_DBG_EN: when defined, adds outputs dbg_we (1), dbg_wr (AW) and dbg_wd (XLEN), registered copies of the last accepted write (reset 0), plus dbg_wcnt (32), a free-running count of accepted writes that wraps at 2^32. When undefined, these ports and their logic are absent and the port list is as above.

Test Plan:
- Reset, then read ports 0/1 at addrs 5/0 -> rd_data 0/0; busy 0, pend_cnt 0, stall 0.
- WB write x5=0xDEADBEEF, same cycle read x5 -> 0xDEADBEEF (write-through); next cycle array returns it; write x0=1 -> x0 reads 0.
- ex_we x7=0x11, mem_we x7=0x22, wb_we x7=0x33, all in one cycle -> read x7 = 0x11; drop ex_we -> 0x22; drop mem_we -> 0x33.
- Issue long to x9; next cycle read x9 with rd_used=1 -> stall=1, pend_cnt=1; same read with rd_used=0 -> stall=0; wb_long to x9 with wd=0x55 -> stall=0 that cycle, rd_data=0x55, busy[9] clears at the edge.
- x9 busy, issue long to x9 -> stall=1 (WAW), busy unchanged; same-cycle wb_long clear of x9 plus new issue to x9 -> stall=0, busy[9] remains 1, pend_cnt 1.
- Issue long to x3, x4, x5 -> pend_cnt 3; assert rst_n=0 asynchronously mid-cycle -> busy 0, pend_cnt 0, stall 0 immediately, all reads 0.
